seq_shift_add_mult: RTL and testbench

- Parametrised, sequential shift-and-add multiplier.
- Successor to the 4-bit combinational multiply: generalised width, signed/unsigned mode per operation, optional early termination, valid/ready handshakes on both sides.
- Processes one multiplier bit per clock and holds a single operation in flight.
- Sits between an operand producer and a result consumer in the arithmetic datapath.

---
 rtl/mult_pkg.sv | 31 +++
 rtl/seq_shift_add_mult_if.sv | 28 ++
 rtl/mult_sign_fix.sv | 13 +
 rtl/seq_shift_add_mult.sv | 140 ++++++++++++++
 tb/tb_seq_shift_add_mult.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   state_e   : controller states (idle, per-bit calculation, sign fix-up, result hold)
//   cnt_width : bit-count register width for a given operand width, clog2(width)+1
//   abs_val   : two's-complement magnitude of a width-bit value held in a 32-bit container
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  localparam int unsigned MaxWidth = 32;

  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // The caller truncates the result to width bits. For the most negative value the
  // low width bits come out as 2^(width-1), which is the correct unsigned magnitude.
  function automatic logic [MaxWidth-1:0] abs_val(logic [MaxWidth-1:0] x, int unsigned width);
    logic [MaxWidth-1:0] r;
    r = x;
    if (x[width-1]) begin
      r = ~x + MaxWidth'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Operand/result handshake bundle for seq_shift_add_mult.
//   in_valid/in_ready   : operand channel carrying a, b, is_signed
//   out_valid/out_ready : result channel carrying p (2*WIDTH bits)
//   busy                : multiplier is stepping or fixing the sign
// master = producer/consumer side, slave = multiplier side.
interface seq_shift_add_mult_if #(
  parameter int unsigned WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negate applied to the finished accumulator.
//   neg  : 1 = result must be negated
//   acc  : unsigned magnitude product
//   prod : acc or -acc (mod 2^WIDTH); -0 stays 0
module mult_sign_fix #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] prod
);
  assign prod = neg ? (~acc + WIDTH'(1)) : acc;
endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, one operation in flight.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : seq_shift_add_mult_if slave modport (operand and result handshakes, busy)
// Signed operands are reduced to magnitudes at accept; the product sign is applied in FIX.
// EARLY_EXIT=1 leaves CALC once the remaining multiplier bits are all zero.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  seq_shift_add_mult_if.slave bus
);

  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned CntW  = cnt_width(WIDTH);

  state_e state_q, state_d;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [ProdW-1:0] acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             neg_q;
  logic [ProdW-1:0] p_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] mcand_in;
  logic [WIDTH-1:0] mplier_in;
  logic             neg_in;
  logic [WIDTH-1:0] mplier_shr;
  logic [ProdW-1:0] addend;
  logic [ProdW-1:0] p_fix;
  logic             last_step;

  // Operand conditioning at accept.
  always_comb begin
    mcand_in  = bus.a;
    mplier_in = bus.b;
    neg_in    = 1'b0;
    if (bus.is_signed) begin
      mcand_in  = WIDTH'(abs_val(MaxWidth'(bus.a), WIDTH));
      mplier_in = WIDTH'(abs_val(MaxWidth'(bus.b), WIDTH));
      neg_in    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
  end

  assign mplier_shr = mplier_q >> 1;
  assign addend     = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
  // cnt is compared before the step, so the WIDTH-th step is the final one.
  assign last_step  = (cnt_q == CntW'(WIDTH - 1)) || (EARLY_EXIT && (mplier_shr == '0));

  mult_sign_fix #(
    .WIDTH(ProdW)
  ) u_sign_fix (
    .neg (neg_q),
    .acc (acc_q),
    .prod(p_fix)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. out_valid is always set in DONE, so out_ready alone completes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.in_valid) state_d = StCalc;
      StCalc: if (last_step) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    unique case (state_q)
      StIdle:        bus.in_ready = 1'b1;
      StCalc, StFix: bus.busy     = 1'b1;
      default:       ;
    endcase
  end

  // Shift/add datapath and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            mcand_q  <= mcand_in;
            mplier_q <= mplier_in;
            neg_q    <= neg_in;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        StCalc: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + addend;
          end
          mplier_q <= mplier_shr;
          cnt_q    <= cnt_q + CntW'(1);
        end
        StFix: begin
          p_q         <= p_fix;
          out_valid_q <= 1'b1;
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.p         = p_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: several instances at different widths/modes, directed
// cases with known products and latencies, then randomized ops against an arithmetic model.
module tb_seq_shift_add_mult;

  localparam int NDut = 5;
  localparam int WS [NDut] = '{4, 8, 8, 6, 16};
  localparam bit EES [NDut] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst;
  logic [31:0] tb_a, tb_b;
  logic tb_sgn, tb_ordy;
  logic [NDut-1:0] tb_vld;

  logic [63:0] p_s [NDut];
  logic ov_s [NDut];
  logic ir_s [NDut];
  logic busy_s [NDut];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    seq_shift_add_mult_if #(.WIDTH(WS[g])) bus_if ();
    assign bus_if.in_valid  = tb_vld[g];
    assign bus_if.a         = tb_a[WS[g]-1:0];
    assign bus_if.b         = tb_b[WS[g]-1:0];
    assign bus_if.is_signed = tb_sgn;
    assign bus_if.out_ready = tb_ordy;
    assign p_s[g]    = 64'(bus_if.p);
    assign ov_s[g]   = bus_if.out_valid;
    assign ir_s[g]   = bus_if.in_ready;
    assign busy_s[g] = bus_if.busy;
    seq_shift_add_mult #(
      .WIDTH(WS[g]),
      .EARLY_EXIT(EES[g])
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Operand value as an integer under the given interpretation.
  function automatic longint to_val(int w, logic [31:0] v, logic sg);
    longint u;
    u = longint'(v) & ((longint'(1) << w) - 1);
    if (sg && u[w-1]) u = u - (longint'(1) << w);
    return u;
  endfunction

  function automatic logic [63:0] model_prod(int w, logic [31:0] av, logic [31:0] bv, logic sg);
    longint r;
    r = to_val(w, av, sg) * to_val(w, bv, sg);
    return 64'(r) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic int model_lat(int w, bit ee, logic [31:0] bv, logic sg);
    longint mag;
    int k;
    if (!ee) return w + 1;
    mag = to_val(w, bv, sg);
    if (mag < 0) mag = -mag;
    k = 1;
    for (int i = 0; i < w; i++) if (mag[i]) k = i + 1;
    return k + 1;
  endfunction

  // One full transaction on instance d; called and returning on a negedge.
  task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input logic sg, input int idle_cyc, input int hold_cyc, input bit poke,
                        output logic [63:0] pr, output int lat);
    logic [63:0] exp_p;
    bit got;
    exp_p = model_prod(WS[d], av, bv, sg);
    tb_ordy = 1'b0;
    repeat (idle_cyc) @(negedge clk);
    check_eq("in_ready_idle", 64'(ir_s[d]), 64'd1);
    tb_a = av;
    tb_b = bv;
    tb_sgn = sg;
    tb_vld[d] = 1'b1;
    @(negedge clk);
    tb_vld[d] = 1'b0;
    tb_a = $urandom;
    tb_b = $urandom;
    tb_sgn = ~sg;
    check_eq("busy_calc", 64'(busy_s[d]), 64'd1);
    check_eq("in_ready_calc", 64'(ir_s[d]), 64'd0);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 80 && !got; i++) begin
      @(negedge clk);
      if (ov_s[d]) begin
        got = 1'b1;
        lat = i;
      end
    end
    check_eq("out_valid_seen", 64'(got), 64'd1);
    check_eq("latency", 64'(lat), 64'(model_lat(WS[d], EES[d], bv, sg)));
    pr = p_s[d];
    check_eq("product", pr, exp_p);
    for (int i = 0; i < hold_cyc; i++) begin
      if (poke) begin
        tb_vld[d] = 1'b1;
        tb_a = $urandom;
        tb_b = $urandom;
      end
      @(negedge clk);
      check_eq("hold_p", p_s[d], exp_p);
      check_eq("hold_valid", 64'(ov_s[d]), 64'd1);
      check_eq("hold_in_ready", 64'(ir_s[d]), 64'd0);
      check_eq("hold_busy", 64'(busy_s[d]), 64'd0);
    end
    tb_vld[d] = 1'b0;
    tb_ordy = 1'b1;
    @(negedge clk);
    check_eq("post_valid", 64'(ov_s[d]), 64'd0);
    check_eq("post_in_ready", 64'(ir_s[d]), 64'd1);
    check_eq("post_busy", 64'(busy_s[d]), 64'd0);
  endtask

  initial begin
    logic [63:0] pr;
    int lat;
    bit seen;
    logic [31:0] ra, rb;
    int w;

    rst = 1'b1;
    tb_vld = '0;
    tb_ordy = 1'b0;
    tb_a = '0;
    tb_b = '0;
    tb_sgn = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDut; d++) begin
      check_eq("rst_p", p_s[d], 64'd0);
      check_eq("rst_valid", 64'(ov_s[d]), 64'd0);
      check_eq("rst_in_ready", 64'(ir_s[d]), 64'd1);
      check_eq("rst_busy", 64'(busy_s[d]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=4 unsigned, fixed latency
    run_op(0, 32'd3, 32'd5, 1'b0, 0, 0, 1'b0, pr, lat);
    check_eq("u4_3x5", pr, 64'd15);
    check_eq("u4_lat", 64'(lat), 64'd5);
    run_op(0, 32'd15, 32'd1, 1'b0, 1, 0, 1'b0, pr, lat);
    check_eq("u4_15x1", pr, 64'd15);
    run_op(0, 32'd10, 32'd3, 1'b0, 0, 0, 1'b0, pr, lat);
    check_eq("u4_10x3", pr, 64'd30);
    run_op(0, 32'd8, 32'd8, 1'b0, 0, 0, 1'b0, pr, lat);
    check_eq("u4_8x8", pr, 64'd64);
    run_op(0, 32'd0, 32'd15, 1'b0, 0, 0, 1'b0, pr, lat);
    check_eq("u4_0x15", pr, 64'd0);
    check_eq("u4_lat_zero", 64'(lat), 64'd5);

    // WIDTH=8 signed
    run_op(1, 32'hFD, 32'd5, 1'b1, 0, 0, 1'b0, pr, lat);
    check_eq("s8_m3x5", pr, 64'hFFF1);
    run_op(1, 32'h80, 32'h80, 1'b1, 0, 0, 1'b0, pr, lat);
    check_eq("s8_min_x_min", pr, 64'h4000);
    run_op(1, 32'h7F, 32'hFF, 1'b1, 0, 0, 1'b0, pr, lat);
    check_eq("s8_127xm1", pr, 64'hFF81);
    run_op(1, 32'h80, 32'h00, 1'b1, 0, 0, 1'b0, pr, lat);
    check_eq("s8_min_x_0", pr, 64'd0);

    // Backpressure with ignored in_valid while holding
    run_op(1, 32'd100, 32'd3, 1'b0, 0, 10, 1'b1, pr, lat);
    check_eq("bp_100x3", pr, 64'd300);

    // Early exit latencies
    run_op(2, 32'd200, 32'd1, 1'b0, 0, 0, 1'b0, pr, lat);
    check_eq("ee_lat_b1", 64'(lat), 64'd2);
    check_eq("ee_p_b1", pr, 64'd200);
    run_op(2, 32'd77, 32'h10, 1'b0, 0, 0, 1'b0, pr, lat);
    check_eq("ee_lat_b10", 64'(lat), 64'd6);
    check_eq("ee_p_b10", pr, 64'd1232);
    run_op(2, 32'd255, 32'h80, 1'b0, 0, 0, 1'b0, pr, lat);
    check_eq("ee_lat_b80", 64'(lat), 64'd9);
    check_eq("ee_p_b80", pr, 64'd32640);
    run_op(2, 32'd9, 32'd0, 1'b0, 0, 0, 1'b0, pr, lat);
    check_eq("ee_lat_b0", 64'(lat), 64'd2);

    // Reset in the middle of CALC aborts the op
    tb_a = 32'd200;
    tb_b = 32'd200;
    tb_sgn = 1'b0;
    tb_ordy = 1'b1;
    tb_vld[1] = 1'b1;
    @(negedge clk);
    tb_vld[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", 64'(busy_s[1]), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 64'(ov_s[1]), 64'd0);
    check_eq("midrst_p", p_s[1], 64'd0);
    check_eq("midrst_in_ready", 64'(ir_s[1]), 64'd1);
    check_eq("midrst_busy", 64'(busy_s[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ov_s[1]) seen = 1'b1;
    end
    check_eq("midrst_no_result", 64'(seen), 64'd0);
    run_op(1, 32'd12, 32'd12, 1'b0, 0, 0, 1'b0, pr, lat);
    check_eq("after_rst_12x12", pr, 64'd144);

    // Randomized ops on WIDTH=6 and WIDTH=16
    for (int n = 0; n < 1000; n++) begin
      int d;
      d = (n < 500) ? 3 : 4;
      w = WS[d];
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'd1 << (w - 1);
      if ($urandom_range(0, 7) == 0) rb = 32'd1 << (w - 1);
      if ($urandom_range(0, 9) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) ra = 32'd0;
      run_op(d, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)), pr, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
